booth_mul_ctrl: RTL

- Multi-cycle controller that shares one instance of the team's combinational 32x32 signed Booth/Wallace multiplier between two requesters.
- Requesters are, for example, the integer pipeline and the divide/MAC unit.
- The block performs round-robin arbitration and latches operands for a fixed multicycle window.
- It applies sign/unsigned correction for the four RV-style multiply ops, then returns a tagged 32-bit result over a valid/ready handshake.

---
 rtl/booth_mul_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/booth_mul_ctrl.sv
// booth_mul_ctrl: shares one combinational 32x32 signed Booth multiplier
// between two requesters. Round-robin grant, operands held for a fixed
// multicycle window, RV-style signedness correction, tagged response.

// Radix-4 Booth multiplier, signed x signed -> 64-bit product.
// Purely combinational; the controller gives it MUL_CYCLES cycles to settle.
module booth_mul32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] p_o
);
    logic [32:0] b_ext;
    logic [63:0] a_sx;
    logic [63:0] a_sx2;
    logic [63:0] pp;
    logic [63:0] acc;
    logic [2:0]  trip;

    assign b_ext = {b_i, 1'b0};
    assign a_sx  = {{32{a_i[31]}}, a_i};
    assign a_sx2 = a_sx << 1;

    // Recode b into 16 signed digits in {-2..+2}, sum the shifted partial products
    always_comb begin
        acc  = '0;
        pp   = '0;
        trip = '0;
        for (int i = 0; i < 16; i++) begin
            trip = b_ext[2*i+2 -: 3];
            case (trip)
                3'b001, 3'b010: pp = a_sx;
                3'b011:         pp = a_sx2;
                3'b100:         pp = -a_sx2;
                3'b101, 3'b110: pp = -a_sx;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2*i));
        end
    end

    assign p_o = acc;
endmodule

// Controller. MUL_CYCLES must be in 1..15 (the counter is 4 bits wide).
module booth_mul_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int TAG_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [3:0]         req_op,
    input  logic [63:0]        req_x,
    input  logic [63:0]        req_y,
    input  logic [2*TAG_W-1:0] req_tag,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [TAG_W-1:0]   resp_tag,
    output logic [31:0]        resp_result,
    input  logic               kill,
    output logic               busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [3:0] CNT_INIT  = 4'(MUL_CYCLES - 1);

    state_t             state_q;
    logic               rr_ptr_q;
    logic [3:0]         cnt_q;
    logic [31:0]        x_q;
    logic [31:0]        y_q;
    logic [1:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic               id_q;
    logic               resp_valid_q;
    logic               resp_id_q;
    logic [TAG_W-1:0]   resp_tag_q;
    logic [31:0]        resp_result_q;

    logic               gnt_vld;
    logic               gnt_idx;
    logic [63:0]        prod;
    logic [31:0]        prod_hi;
    logic [31:0]        result_d;

    // Round-robin grant: a lone requester wins, a tie goes to rr_ptr
    always_comb begin
        gnt_vld = |req_valid;
        if (req_valid == 2'b11) gnt_idx = rr_ptr_q;
        else                    gnt_idx = req_valid[1];
    end

    // Ready only in IDLE and never while reset is asserted, so a handshake
    // coincident with reset cannot be seen as accepted by the requester.
    assign req_ready = (state_q == IDLE && !rst && gnt_vld) ? (2'b01 << gnt_idx) : 2'b00;

    // The multiplier sees only latched operands, so its inputs are stable
    // for the whole EXEC window.
    booth_mul32 u_mul (
        .a_i (x_q),
        .b_i (y_q),
        .p_o (prod)
    );

    assign prod_hi = prod[63:32];

    // High-word correction turning the signed product into SU / UU forms
    always_comb begin
        case (op_q)
            OP_MUL:    result_d = prod[31:0];
            OP_MULH:   result_d = prod_hi;
            OP_MULHSU: result_d = prod_hi + (y_q[31] ? x_q : 32'd0);
            default:   result_d = prod_hi + (x_q[31] ? y_q : 32'd0)
                                          + (y_q[31] ? x_q : 32'd0);
        endcase
    end

    // Main FSM: accept, hold operands for MUL_CYCLES, present result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= 1'b0;
            cnt_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            op_q          <= '0;
            tag_q         <= '0;
            id_q          <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_tag_q    <= '0;
            resp_result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // kill is ignored here so it cannot block a grant
                    if (gnt_vld) begin
                        x_q      <= req_x[32*gnt_idx +: 32];
                        y_q      <= req_y[32*gnt_idx +: 32];
                        op_q     <= req_op[2*gnt_idx +: 2];
                        tag_q    <= req_tag[TAG_W*gnt_idx +: TAG_W];
                        id_q     <= gnt_idx;
                        rr_ptr_q <= ~gnt_idx;
                        cnt_q    <= CNT_INIT;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    if (kill) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        resp_result_q <= result_d;
                        resp_id_q     <= id_q;
                        resp_tag_q    <= tag_q;
                        resp_valid_q  <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    // kill wins over a same-cycle response handshake
                    if (kill || resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_tag    = resp_tag_q;
    assign resp_result = resp_result_q;
    assign busy        = (state_q != IDLE);
endmodule
